// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier: signed/unsigned, short (W) or long (2W) result, optional accumulate, N/Z flags.
// Latency: start-to-done is k+1 edges, k = WIDTH/RBITS RUN cycles (data dependent when MULT_EARLY_TERM_EN is defined).
// Backpressure: none downstream; start is only accepted while ready=1, and start while busy is ignored.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, abort         launch (taken only in IDLE) / cancel in-flight operation (no done)
//   sgn, lng, accum      two's complement operands / 2W-bit result / add acc0 to product
//   in0, in1, acc0       multiplier (scanned), multiplicand, accumulator (low W bits only in short mode)
//   ready, busy, done    idle / RUN or FIXUP / one-cycle result-valid pulse
//   result, result_n/z   product (held until next done), sign and zero flags of the tested width
// Build option: define MULT_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are zero.
module iter_multiplier #(
   parameter int WIDTH = 32,
   parameter int RBITS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 sgn,
   input  logic                 lng,
   input  logic                 accum,
   input  logic [WIDTH-1:0]     in0,
   input  logic [WIDTH-1:0]     in1,
   input  logic [2*WIDTH-1:0]   acc0,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 result_n,
   output logic                 result_z
);

   localparam int STEPS = WIDTH / RBITS;
   localparam int CW    = $clog2(STEPS + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;

   state_t               state;
   logic [WIDTH-1:0]     bitfield;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   partial;
   logic [2*WIDTH-1:0]   acc_q;
   logic                 neg_q;
   logic                 lng_q;
   logic                 accum_q;
   logic [CW-1:0]        cnt;

   // Operand magnitudes. The most-negative value negates to itself, which
   // read as unsigned is exactly its magnitude 2^(W-1).
   logic [WIDTH-1:0]     mag0;
   logic [WIDTH-1:0]     mag1;
   logic                 neg_in;

   always_comb begin
      mag0   = (sgn && in0[WIDTH-1]) ? -in0 : in0;
      mag1   = (sgn && in1[WIDTH-1]) ? -in1 : in1;
      neg_in = sgn & (in0[WIDTH-1] ^ in1[WIDTH-1]);
   end

   // One RUN step: retire RBITS multiplier bits.
   logic [2*WIDTH-1:0]   step_sum;
   logic [2*WIDTH-1:0]   partial_nxt;
   logic [WIDTH-1:0]     bitfield_nxt;
   logic [2*WIDTH-1:0]   mcand_nxt;
   logic [CW-1:0]        cnt_nxt;
   logic                 run_last;

   always_comb begin
      step_sum = '0;
      for (int i = 0; i < RBITS; i++) begin
         if (bitfield[i]) begin
            step_sum = step_sum + (mcand << i);
         end
      end
      partial_nxt  = partial + step_sum;
      bitfield_nxt = bitfield >> RBITS;
      mcand_nxt    = mcand << RBITS;
      cnt_nxt      = cnt + CW'(1);
`ifdef MULT_EARLY_TERM_EN
      run_last     = (bitfield_nxt == '0) || (cnt_nxt == CW'(STEPS));
`else
      run_last     = (cnt_nxt == CW'(STEPS));
`endif
   end

   // FIXUP: apply sign, accumulate, truncate to the selected width.
   logic [2*WIDTH-1:0]   signed_p;
   logic [2*WIDTH-1:0]   acc_add;
   logic [2*WIDTH-1:0]   sum_p;
   logic [2*WIDTH-1:0]   fix_res;
   logic                 fix_n;
   logic                 fix_z;

   always_comb begin
      signed_p = neg_q ? -partial : partial;
      acc_add  = lng_q ? acc_q : {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
      sum_p    = accum_q ? (signed_p + acc_add) : signed_p;
      fix_res  = lng_q ? sum_p : {{WIDTH{1'b0}}, sum_p[WIDTH-1:0]};
      fix_n    = lng_q ? fix_res[2*WIDTH-1] : fix_res[WIDTH-1];
      fix_z    = lng_q ? (fix_res == '0) : (fix_res[WIDTH-1:0] == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         done     <= 1'b0;
         result   <= '0;
         result_n <= 1'b0;
         result_z <= 1'b1;
         bitfield <= '0;
         mcand    <= '0;
         partial  <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         lng_q    <= 1'b0;
         accum_q  <= 1'b0;
         cnt      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // abort in the same cycle drops the start
               if (start && !abort) begin
                  bitfield <= mag0;
                  mcand    <= {{WIDTH{1'b0}}, mag1};
                  partial  <= '0;
                  acc_q    <= acc0;
                  neg_q    <= neg_in;
                  lng_q    <= lng;
                  accum_q  <= accum;
                  cnt      <= '0;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state <= S_IDLE;
               end else begin
                  partial  <= partial_nxt;
                  bitfield <= bitfield_nxt;
                  mcand    <= mcand_nxt;
                  cnt      <= cnt_nxt;
                  if (run_last) begin
                     state <= S_FIXUP;
                  end
               end
            end
            S_FIXUP: begin
               state <= S_IDLE;
               if (!abort) begin
                  result   <= fix_res;
                  result_n <= fix_n;
                  result_z <= fix_z;
                  done     <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy  = (state != S_IDLE);
   assign ready = ~busy;

endmodule

// File: tb/tb_iter_multiplier.sv
module tb_iter_multiplier;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst, start, abort, sgn, lng, accum;
   logic [W-1:0]   in0, in1;
   logic [2*W-1:0] acc0;
   logic           ready, busy, done, result_n, result_z;
   logic [2*W-1:0] result;

   iter_multiplier #(.WIDTH(W), .RBITS(2)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .sgn(sgn), .lng(lng), .accum(accum),
      .in0(in0), .in1(in1), .acc0(acc0),
      .ready(ready), .busy(busy), .done(done),
      .result(result), .result_n(result_n), .result_z(result_z)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] a, b;
      logic        s, l, ac;
      logic [63:0] c;
      logic [63:0] res;
      logic        n, z;
   } vec_t;

   typedef struct {
      logic [63:0] res;
      logic        n, z;
      int          lat;
      int          t0;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[10];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] a, b, input logic s, l, ac,
                               input logic [63:0] c, res, input logic n, z);
      vec_t v;
      v.a = a; v.b = b; v.s = s; v.l = l; v.ac = ac; v.c = c;
      v.res = res; v.n = n; v.z = z;
      return v;
   endfunction

   // Reference: sign-extend, multiply mod 2^64, accumulate, truncate.
   function automatic logic [63:0] model(input logic [31:0] a, b, input logic s, l, ac,
                                         input logic [63:0] c);
      logic [63:0] xa, xb, p;
      xa = s ? {{32{a[31]}}, a} : {32'b0, a};
      xb = s ? {{32{b[31]}}, b} : {32'b0, b};
      p  = xa * xb;
      if (ac) p = p + (l ? c : {32'b0, c[31:0]});
      if (!l) p = {32'b0, p[31:0]};
      return p;
   endfunction

   function automatic int exp_lat(input logic [31:0] a, input logic s);
`ifdef MULT_EARLY_TERM_EN
      logic [31:0] m;
      int bl, k;
      m  = (s && a[31]) ? (~a + 32'd1) : a;
      bl = 0;
      for (int b = 0; b < 32; b++) if (m[b]) bl = b + 1;
      k = (bl + 1) / 2;
      if (k < 1) k = 1;
      return k + 1;
`else
      return 17;
`endif
   endfunction

   // Drive start now (caller is away from the edge), push expectation.
   task automatic launch(input logic [31:0] a, b, input logic s, l, ac,
                         input logic [63:0] c, res, input logic n, z);
      exp_t e;
      in0 = a; in1 = b; sgn = s; lng = l; accum = ac; acc0 = c;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e.res = res; e.n = n; e.z = z; e.lat = exp_lat(a, s); e.t0 = cyc;
      sb.push_back(e);
   endtask

   task automatic drive(input vec_t v);
      @(negedge clk);
      launch(v.a, v.b, v.s, v.l, v.ac, v.c, v.res, v.n, v.z);
   endtask

   task automatic wait_done(input string name, input int budget);
      exp_t e;
      bit   got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL %s: done with empty scoreboard, result %h", name, result);
            end else begin
               e = sb.pop_front();
               chk({name, "_res"}, result, e.res);
               chk({name, "_n"}, 64'(result_n), 64'(e.n));
               chk({name, "_z"}, 64'(result_z), 64'(e.z));
               chk({name, "_lat"}, 64'(cyc - e.t0), 64'(e.lat));
            end
         end
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: no done within %0d cycles, got busy=%b expected done=1", name, budget, busy);
         sb.delete();
      end
   endtask

   initial begin
      vec_t v;
      logic [63:0] r;
      int done_cnt;

      rst = 1'b1; start = 1'b0; abort = 1'b0; sgn = 1'b0; lng = 1'b0; accum = 1'b0;
      in0 = '0; in1 = '0; acc0 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_n", 64'(result_n), 64'd0);
      chk("rst_z", 64'(result_z), 64'd1);
      rst = 1'b0;

      //           in0            in1           s     l     ac    acc0                    result                  n     z
      tbl[0] = mk(32'd5,         32'd7,        1'b0, 1'b0, 1'b0, 64'd0,                  64'd35,                 1'b0, 1'b0);
      tbl[1] = mk(32'hFFFFFFFE,  32'd3,        1'b1, 1'b1, 1'b0, 64'd0,                  64'hFFFFFFFF_FFFFFFFA,  1'b1, 1'b0);
      tbl[2] = mk(32'h80000000,  32'h80000000, 1'b1, 1'b1, 1'b0, 64'd0,                  64'h40000000_00000000,  1'b0, 1'b0);
      tbl[3] = mk(32'h0000FFFF,  32'h0000FFFF, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0001FFFF, 64'd0,                  1'b0, 1'b1);
      tbl[4] = mk(32'hFFFFFFFF,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 64'd0,                  64'hFFFFFFFE_00000001,  1'b1, 1'b0);
      tbl[5] = mk(32'd0,         32'h1234,     1'b0, 1'b0, 1'b0, 64'd0,                  64'd0,                  1'b0, 1'b1);
      tbl[6] = mk(32'hFFFFFFFF,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 64'd0,                  64'd1,                  1'b0, 1'b0);
      tbl[7] = mk(32'hFFFFFFFD,  32'd5,        1'b1, 1'b1, 1'b1, 64'd15,                 64'd0,                  1'b0, 1'b1);
      tbl[8] = mk(32'h00010000,  32'h00008000, 1'b0, 1'b0, 1'b0, 64'd0,                  64'h00000000_80000000,  1'b1, 1'b0);
      tbl[9] = mk(32'd7,         32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 64'd0,                  64'h00000000_FFFFFFF9,  1'b1, 1'b0);

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i]);
         wait_done($sformatf("tbl%0d", i), 40);
      end

      for (int i = 0; i < 16; i++) begin
         v.a  = (i % 2 == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
         v.b  = 32'($urandom);
         v.s  = 1'($urandom_range(0, 1));
         v.l  = 1'($urandom_range(0, 1));
         v.ac = 1'($urandom_range(0, 1));
         v.c  = {32'($urandom), 32'($urandom)};
         r    = model(v.a, v.b, v.s, v.l, v.ac, v.c);
         v.res = r;
         v.n  = v.l ? r[63] : r[31];
         v.z  = v.l ? (r == 64'd0) : (r[31:0] == 32'd0);
         drive(v);
         wait_done($sformatf("rnd%0d", i), 40);
      end

      // start while busy is ignored: new operands at E3 must not disturb op A
      drive(mk(32'h12345, 32'h100, 1'b0, 1'b0, 1'b0, 64'd0, 64'h1234500, 1'b0, 1'b0));
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      in0 = 32'd9; in1 = 32'd9; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("ignore", 40);

      // abort at E5: no done, result unchanged
      drive(mk(32'hFFFFFFFF, 32'd3, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0));
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      in0 = 32'd11; in1 = 32'd13; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("abort_ready", 64'(ready), 64'd1);
      done_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_result", result, 64'h1234500);

      // abort and start together in IDLE: start dropped
      @(negedge clk);
      in0 = 32'd3; in1 = 32'd3; start = 1'b1; abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("idle_abort_busy", 64'(busy), 64'd0);

      // back-to-back: second start in the done cycle
      drive(mk(32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 64'd0, 64'd35, 1'b0, 1'b0));
      wait_done("b2b_a", 40);
      chk("b2b_ready_in_done", 64'(ready), 64'd1);
      launch(32'd100, 32'd200, 1'b0, 1'b1, 1'b0, 64'd0, 64'd20000, 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b_done_drop", 64'(done), 64'd0);
      chk("b2b_busy", 64'(busy), 64'd1);
      wait_done("b2b_b", 40);

      // reset mid-RUN at E4
      drive(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0));
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      @(negedge clk);
      chk("mrst_ready", 64'(ready), 64'd1);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_done", 64'(done), 64'd0);
      chk("mrst_result", result, 64'd0);
      chk("mrst_n", 64'(result_n), 64'd0);
      chk("mrst_z", 64'(result_z), 64'd1);
      rst = 1'b0;
      drive(mk(32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 64'd0, 64'd42, 1'b0, 1'b0));
      wait_done("post_rst", 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
